// File: rtl/ddc_gain_pkg.sv
// Shared types and rounding/saturation helper for the DDC gain/pass selector.
// Gain shift field is carried at CFG_GAIN_W bits; GAINBITWIDTH must not exceed it.
package ddc_gain_pkg;

    localparam int DEF_NCH            = 2;
    localparam int DEF_INBITWIDTH     = 22;
    localparam int DEF_FILTERBITWIDTH = 18;
    localparam int DEF_GAINBITWIDTH   = 3;
    localparam int DEF_SATCNTWIDTH    = 16;

    localparam int CFG_GAIN_W = 5;
    localparam int ARITH_W    = 64;

    typedef struct packed {
        logic                  bypass;
        logic [CFG_GAIN_W-1:0] gain;
    } cfg_t;

    typedef struct packed {
        logic                      ovf;
        logic signed [ARITH_W-1:0] value;
    } sat_res_t;

    // Drop 'drop' LSBs with round-half-up, then clamp to a signed fw-bit range.
    function automatic sat_res_t sat_round(input logic signed [ARITH_W-1:0] s,
                                           input int drop,
                                           input int fw);
        sat_res_t                  res;
        logic signed [ARITH_W-1:0] one;
        logic signed [ARITH_W-1:0] tmp;
        logic signed [ARITH_W-1:0] r;
        logic signed [ARITH_W-1:0] hi;
        logic signed [ARITH_W-1:0] lo;
        logic                      rbit;
        one  = {{(ARITH_W-1){1'b0}}, 1'b1};
        tmp  = s >>> (drop - 1);
        rbit = tmp[0];
        r    = s >>> drop;
        r    = r + $signed({{(ARITH_W-1){1'b0}}, rbit});
        hi   = (one <<< (fw - 1)) - one;
        lo   = -(one <<< (fw - 1));
        if (r > hi) begin
            res.value = hi;
            res.ovf   = 1'b1;
        end else if (r < lo) begin
            res.value = lo;
            res.ovf   = 1'b1;
        end else begin
            res.value = r;
            res.ovf   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/gain_round_sat.sv
// One channel of the wide-path arithmetic: power-of-two gain, round-half-up, saturate.
module gain_round_sat
    import ddc_gain_pkg::*;
#(
    parameter int IW = DEF_INBITWIDTH,
    parameter int FW = DEF_FILTERBITWIDTH,
    parameter int GW = DEF_GAINBITWIDTH
) (
    input  logic [IW-1:0]         din,
    input  logic [CFG_GAIN_W-1:0] gain,
    output logic [FW-1:0]         dout,
    output logic                  ovf
);

    localparam int SW = IW + 2**GW - 1;

    logic signed [SW-1:0] s_full;
    sat_res_t             res;
    logic                 unused_hi;

    always_comb begin
        s_full = SW'($signed(din)) <<< gain;
        res    = sat_round(ARITH_W'(s_full), IW - FW, FW);
        dout   = res.value[FW-1:0];
        ovf    = res.ovf;
    end

    // Above FW the clamped result is pure sign extension.
    assign unused_hi = ^res.value[ARITH_W-1:FW];

endmodule

// File: rtl/gain_pass_cntrl_mc.sv
// Multi-channel FIR-input pass/gain selector with double-buffered config.
// Define GAIN_PASS_SAT_CNT_EN to build the saturated-sample counter.
module gain_pass_cntrl_mc
    import ddc_gain_pkg::*;
#(
    parameter int NCH            = DEF_NCH,
    parameter int INBITWIDTH     = DEF_INBITWIDTH,
    parameter int FILTERBITWIDTH = DEF_FILTERBITWIDTH,
    parameter int GAINBITWIDTH   = DEF_GAINBITWIDTH,
    parameter int SATCNTWIDTH    = DEF_SATCNTWIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gain_indicator,
    input  logic [GAINBITWIDTH-1:0]       cfg_gain,
    input  logic                          cfg_bypass,
    input  logic                          config_sync,
    input  logic [NCH*FILTERBITWIDTH-1:0] dataa,
    input  logic                          dataa_flag,
    input  logic [NCH*INBITWIDTH-1:0]     datab,
    input  logic                          datab_flag,
    input  logic                          ovf_clr,
    output logic [NCH*FILTERBITWIDTH-1:0] data_sel,
    output logic                          data_sel_flag,
    output logic [NCH-1:0]                overflow,
    output logic                          ovf_sticky,
    output logic [SATCNTWIDTH-1:0]        sat_cnt
);

    localparam int FW = FILTERBITWIDTH;
    localparam int IW = INBITWIDTH;

    cfg_t               shadow_q, shadow_d;
    cfg_t               active_q, active_d;
    cfg_t               s1_cfg_q, s1_cfg_d;
    logic               s1_flag_q, s1_flag_d;
    logic [NCH*FW-1:0]  s1_dataa_q, s1_dataa_d;
    logic [NCH*IW-1:0]  s1_datab_q, s1_datab_d;
    logic [NCH*FW-1:0]  data_sel_q, data_sel_d;
    logic [NCH-1:0]     overflow_q, overflow_d;
    logic               flag_q, flag_d;
    logic               sticky_q, sticky_d;
    logic [NCH*FW-1:0]  gain_dout;
    logic [NCH-1:0]     gain_ovf;
    logic               sat_event;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            gain_round_sat #(
                .IW (IW),
                .FW (FW),
                .GW (GAINBITWIDTH)
            ) u_grs (
                .din  (s1_datab_q[gi*IW +: IW]),
                .gain (s1_cfg_q.gain),
                .dout (gain_dout[gi*FW +: FW]),
                .ovf  (gain_ovf[gi])
            );
        end
    endgenerate

    always_comb begin
        shadow_d = shadow_q;
        if (gain_indicator) begin
            shadow_d.bypass = cfg_bypass;
            shadow_d.gain   = CFG_GAIN_W'(cfg_gain);
        end
        // Sync reads the pre-update shadow, so a simultaneous load lands one sync later.
        active_d   = config_sync ? shadow_q : active_q;

        s1_flag_d  = active_q.bypass ? dataa_flag : datab_flag;
        s1_cfg_d   = active_q;
        s1_dataa_d = dataa;
        s1_datab_d = datab;

        flag_d     = s1_flag_q;
        data_sel_d = data_sel_q;
        overflow_d = overflow_q;
        if (s1_flag_q) begin
            if (s1_cfg_q.bypass) begin
                data_sel_d = s1_dataa_q;
                overflow_d = '0;
            end else begin
                data_sel_d = gain_dout;
                overflow_d = gain_ovf;
            end
        end

        sat_event = s1_flag_q && !s1_cfg_q.bypass && (|gain_ovf);
        if (sat_event) begin
            sticky_d = 1'b1;
        end else if (ovf_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q   <= '0;
            active_q   <= '0;
            s1_cfg_q   <= '0;
            s1_flag_q  <= 1'b0;
            s1_dataa_q <= '0;
            s1_datab_q <= '0;
            data_sel_q <= '0;
            overflow_q <= '0;
            flag_q     <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            shadow_q   <= shadow_d;
            active_q   <= active_d;
            s1_cfg_q   <= s1_cfg_d;
            s1_flag_q  <= s1_flag_d;
            s1_dataa_q <= s1_dataa_d;
            s1_datab_q <= s1_datab_d;
            data_sel_q <= data_sel_d;
            overflow_q <= overflow_d;
            flag_q     <= flag_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef GAIN_PASS_SAT_CNT_EN
    logic [SATCNTWIDTH-1:0] sat_cnt_q, sat_cnt_d;

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (ovf_clr) begin
            sat_cnt_d = '0;
        end else if (sat_event && (sat_cnt_q != {SATCNTWIDTH{1'b1}})) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_cnt_q <= '0;
        end else begin
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign sat_cnt = sat_cnt_q;
`else
    assign sat_cnt = '0;
`endif

    assign data_sel      = data_sel_q;
    assign data_sel_flag = flag_q;
    assign overflow      = overflow_q;
    assign ovf_sticky    = sticky_q;

endmodule

// File: tb/tb_gain_pass_cntrl_mc.sv
// Directed bench for gain_pass_cntrl_mc: gain path, rounding, saturation, config timing, bypass, counter.
module tb_gain_pass_cntrl_mc;

    localparam int NCH = 2;
    localparam int IW  = 22;
    localparam int FW  = 18;
    localparam int GW  = 3;
    localparam int CW  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              gain_indicator = 1'b0;
    logic [GW-1:0]     cfg_gain = '0;
    logic              cfg_bypass = 1'b0;
    logic              config_sync = 1'b0;
    logic [NCH*FW-1:0] dataa = '0;
    logic              dataa_flag = 1'b0;
    logic [NCH*IW-1:0] datab = '0;
    logic              datab_flag = 1'b0;
    logic              ovf_clr = 1'b0;
    logic [NCH*FW-1:0] data_sel;
    logic              data_sel_flag;
    logic [NCH-1:0]    overflow;
    logic              ovf_sticky;
    logic [CW-1:0]     sat_cnt;

    int total = 0;
    int bad   = 0;

    gain_pass_cntrl_mc #(
        .NCH            (NCH),
        .INBITWIDTH     (IW),
        .FILTERBITWIDTH (FW),
        .GAINBITWIDTH   (GW),
        .SATCNTWIDTH    (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .gain_indicator (gain_indicator),
        .cfg_gain       (cfg_gain),
        .cfg_bypass     (cfg_bypass),
        .config_sync    (config_sync),
        .dataa          (dataa),
        .dataa_flag     (dataa_flag),
        .datab          (datab),
        .datab_flag     (datab_flag),
        .ovf_clr        (ovf_clr),
        .data_sel       (data_sel),
        .data_sel_flag  (data_sel_flag),
        .overflow       (overflow),
        .ovf_sticky     (ovf_sticky),
        .sat_cnt        (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    function automatic longint ch_out(input int k);
        return longint'($signed(data_sel[k*FW +: FW]));
    endfunction

    // Expected counter value: tracks n only when the counter is built.
    function automatic longint cnt_model(input longint n);
`ifdef GAIN_PASS_SAT_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic run_b(input string tag, input longint v0, input longint v1,
                         input longint e0, input longint e1, input logic [1:0] eo);
        datab      = {IW'(v1), IW'(v0)};
        datab_flag = 1'b1;
        @(negedge clk);
        datab_flag = 1'b0;
        @(negedge clk);
        check({tag, ".flag"}, data_sel_flag, 1);
        check({tag, ".ch0"}, ch_out(0), e0);
        check({tag, ".ch1"}, ch_out(1), e1);
        check({tag, ".ovf"}, overflow, eo);
    endtask

    task automatic load_cfg(input logic [GW-1:0] g, input logic b, input logic sync);
        cfg_gain       = g;
        cfg_bypass     = b;
        gain_indicator = 1'b1;
        config_sync    = sync;
        @(negedge clk);
        gain_indicator = 1'b0;
        config_sync    = 1'b0;
    endtask

    task automatic sync_only();
        config_sync = 1'b1;
        @(negedge clk);
        config_sync = 1'b0;
    endtask

    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst.data", data_sel, 0);
        check("rst.flag", data_sel_flag, 0);
        check("rst.ovf", overflow, 0);
        check("rst.sticky", ovf_sticky, 0);
        check("rst.cnt", sat_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Gain 0: rounding at the dropped-LSB boundary.
        run_b("g0a", 16, 8, 1, 1, 2'b00);
        run_b("g0b", 7, -8, 0, 0, 2'b00);
        check("g0.sticky", ovf_sticky, 0);
        run_b("g0sat", 2097151, -2097152, 131071, -131072, 2'b01);
        check("g0sat.sticky", ovf_sticky, 1);
        check("g0sat.cnt", sat_cnt, cnt_model(1));
        pulse_clr();
        check("clr.sticky", ovf_sticky, 0);
        check("clr.cnt", sat_cnt, 0);

        // Gain 7.
        load_cfg(3'd7, 1'b0, 1'b0);
        sync_only();
        run_b("g7sat", 16384, -16384, 131071, -131072, 2'b01);
        run_b("g7", 100, -100, 800, -800, 2'b00);
        check("g7.cnt", sat_cnt, cnt_model(1));

        // Shadow load without sync does not take effect.
        load_cfg(3'd0, 1'b0, 1'b0);
        sync_only();
        load_cfg(3'd3, 1'b0, 1'b0);
        run_b("nosync", 16, 16, 1, 1, 2'b00);

        // Sync while sample A sits in stage 1 and sample B arrives with the sync.
        datab      = {IW'(16), IW'(16)};
        datab_flag = 1'b1;
        @(negedge clk);
        datab       = {IW'(32), IW'(32)};
        config_sync = 1'b1;
        @(negedge clk);
        check("syncA.flag", data_sel_flag, 1);
        check("syncA.ch0", ch_out(0), 1);
        datab       = {IW'(16), IW'(16)};
        config_sync = 1'b0;
        @(negedge clk);
        check("syncB.ch0", ch_out(0), 2);
        datab_flag = 1'b0;
        @(negedge clk);
        check("syncC.ch0", ch_out(0), 8);
        check("syncC.ch1", ch_out(1), 8);

        // Load and sync together: active takes the old shadow (gain 1).
        load_cfg(3'd1, 1'b0, 1'b0);
        load_cfg(3'd5, 1'b0, 1'b1);
        run_b("both", 16, 16, 2, 2, 2'b00);
        sync_only();
        run_b("g5", 16, 16, 32, 32, 2'b00);
        run_b("g5sat", 1048576, -1048576, 131071, -131072, 2'b11);
        check("g5sat.cnt", sat_cnt, cnt_model(2));

        // Bypass mode.
        load_cfg(3'd0, 1'b1, 1'b0);
        sync_only();
        dataa      = {FW'(17), FW'(-5)};
        dataa_flag = 1'b1;
        datab_flag = 1'b1;
        @(negedge clk);
        dataa_flag = 1'b0;
        datab_flag = 1'b0;
        @(negedge clk);
        check("byp.flag", data_sel_flag, 1);
        check("byp.ch0", ch_out(0), -5);
        check("byp.ch1", ch_out(1), 17);
        check("byp.ovf", overflow, 0);
        dataa = {FW'(99), FW'(-99)};
        for (int i = 0; i < 4; i++) begin
            datab_flag = ~datab_flag;
            @(negedge clk);
            check($sformatf("idle%0d.flag", i), data_sel_flag, 0);
            check($sformatf("idle%0d.ch0", i), ch_out(0), -5);
        end
        datab_flag = 1'b0;

        // Counter: three saturations, then clear colliding with a fourth.
        load_cfg(3'd0, 1'b0, 1'b0);
        sync_only();
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            run_b($sformatf("cnt%0d", i), 2097151, 0, 131071, 0, 2'b01);
        end
        check("cnt3", sat_cnt, cnt_model(3));
        datab      = {IW'(0), IW'(2097151)};
        datab_flag = 1'b1;
        @(negedge clk);
        datab_flag = 1'b0;
        ovf_clr    = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("clrhit.cnt", sat_cnt, 0);
        check("clrhit.sticky", ovf_sticky, 1);

        // Mid-stream reset with a bypass config active and a sample in flight.
        load_cfg(3'd3, 1'b1, 1'b0);
        sync_only();
        dataa      = {FW'(7), FW'(7)};
        dataa_flag = 1'b1;
        @(negedge clk);
        dataa_flag = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst.data", data_sel, 0);
        check("mrst.flag", data_sel_flag, 0);
        check("mrst.ovf", overflow, 0);
        check("mrst.sticky", ovf_sticky, 0);
        check("mrst.cnt", sat_cnt, 0);
        @(negedge clk);
        check("mrst.flag2", data_sel_flag, 0);
        run_b("postrst", 16, 8, 1, 1, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
